fetch_buffer: RTL and testbench
===============================

// Module: fetch_buffer
// PURPOSE
//   Instruction prefetch queue between the F stage (PC + instruction memory) and the D stage.
//   Each entry holds one fetched {pc, instr} pair; a valid/ready handshake sits on both sides.
//   in_ready drives the PC's pc_en, so the PC advances only when an entry can be accepted.
//   flush discards all queued fetches on a control-flow redirect.
// PARAMETERS
//   DEPTH    4   number of entries; power of two, >= 2
//   AW       2   pointer width, = log2(DEPTH)
// PORTS
//   clk        in   1     rising-edge clock
//   reset      in   1     asynchronous, active-low (0 = reset)
//   in_valid   in   1     F stage presents a fetched instruction
//   in_ready   out  1     buffer can accept (drives PC pc_en)
//   in_pc      in   32    PC of fetched instruction (PC_F)
//   in_instr   in   32    fetched instruction word
//   out_valid  out  1     head entry valid for D stage
//   out_ready  in   1     D stage consumes head (0 = D stalled)
//   out_pc     out  32    PC of head entry
//   out_pc8    out  32    out_pc + 8 (jal/jalr link value)
//   out_instr  out  32    instruction word of head entry
//   flush      in   1     synchronous discard of all entries
//   count      out  AW+1  number of occupied entries, 0..DEPTH
// BEHAVIOUR
//   - Storage: circular array of DEPTH {pc, instr} entries, wr_ptr/rd_ptr (AW bits) plus count (AW+1 bits).
//   - Reset (reset==0, async): wr_ptr = rd_ptr = count = 0. Outputs: out_valid=0, in_ready=1, out_pc=0,
//     out_pc8=8, out_instr=0. Array contents are don't-care. Reset mid-operation drops all entries immediately.
//   - in_ready = (count != DEPTH); it depends on state only, with no combinational path from out_ready.
//   - out_valid = (count != 0).
//   - push = in_valid & in_ready; pop = out_valid & out_ready.
//   - push: entry[wr_ptr] <= {in_pc, in_instr}; wr_ptr <= wr_ptr+1 (wraps mod DEPTH).
//   - pop: rd_ptr <= rd_ptr+1 (wraps mod DEPTH).
//   - count update: +1 on push only, -1 on pop only, unchanged on push & pop together.
//   - Full (count==DEPTH): in_ready=0, so a push is impossible even if a pop occurs that cycle.
//     in_ready returns to 1 the cycle after the pop.
//   - Empty (count==0): out_valid=0, out_instr=32'h0000_0000 (nop), out_pc=0, out_pc8=8.
//     out_ready is ignored.
//   - Latency: an entry pushed at edge N is visible on out_* after edge N (one cycle); there is no bypass.
//   - Head outputs are combinational reads of entry[rd_ptr], masked to the empty values when count==0.
//   - flush (sampled at clk edge) has highest priority: ptrs and count go to 0.
//     A push or pop in the same cycle is discarded, and out_valid=0 in the next cycle.
//   - out_pc8 = out_pc + 32'd8, wrapping modulo 2^32 (0xFFFF_FFFC -> 0x0000_0004).
//   - Order is strictly FIFO; no entry is duplicated or dropped except by flush or reset.
// TESTING
//   1. Reset low for 3 cycles, then high; hold in_valid=0 -> out_valid=0, in_ready=1, count=0,
//      out_instr=0, out_pc8=8.
//   2. Push pc=0x3000/0x3004/0x3008/0x300C with out_ready=0 -> count=4, in_ready=0 and out_pc=0x3000.
//      A 5th push (pc=0x3010) is not accepted.
//   3. From full, pulse out_ready=1 for 1 cycle -> out_pc=0x3004, count=3, in_ready=1.
//      Push 0x3010 -> entries drain in order 0x3004..0x3010, verifying wrap of wr_ptr.
//   4. With count=2, assert in_valid and out_ready together for 6 cycles (pc +4 each) -> count stays 2.
//      out_pc sequence is strictly +4 and out_pc8 = out_pc+8.
//   5. With count=3, assert flush together with in_valid=1/out_ready=1 -> next cycle count=0 and out_valid=0.
//      The next push (pc=0x4000) appears at head one cycle later.
//   6. Drop reset to 0 asynchronously mid-cycle with count=2 -> out_valid=0 and count=0 without waiting
//      for a clk edge. Push pc=0xFFFF_FFFC afterwards -> out_pc8=0x0000_0004.

Source files
------------

// File: rtl/fetch_buffer.sv
// fetch_buffer: instruction prefetch FIFO between the F and D stages.
// Holds DEPTH {pc, instr} pairs in a circular array with valid/ready on both
// sides. in_ready depends only on occupancy, so it can drive the PC enable
// without a combinational path from the D-stage stall. flush empties the queue
// on a redirect. Head outputs read out as zeros (a nop) while the queue is empty.
module fetch_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [31:0]   in_pc,
    input  logic [31:0]   in_instr,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [31:0]   out_pc,
    output logic [31:0]   out_pc8,
    output logic [31:0]   out_instr,
    input  logic          flush,
    output logic [AW:0]   count
);

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fb_entry_t;

    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ZERO = '0;
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    fb_entry_t       mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW:0]     cnt_q;
    logic            push;
    logic            pop;
    fb_entry_t       head;

    // Handshake: readiness comes from occupancy alone.
    always_comb begin
        in_ready  = (cnt_q != CNT_FULL);
        out_valid = (cnt_q != CNT_ZERO);
        push      = in_valid & in_ready;
        pop       = out_valid & out_ready;
    end

    // Entry storage; contents need no reset because count gates visibility.
    always_ff @(posedge clk) begin
        if (push && !flush)
            mem[wr_ptr] <= '{pc: in_pc, instr: in_instr};
    end

    // Pointers and occupancy; flush overrides any same-cycle push or pop.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt_q  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt_q  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)
                rd_ptr <= rd_ptr + PTR_ONE;
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + CNT_ONE;
                2'b01:   cnt_q <= cnt_q - CNT_ONE;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // Head read, masked to a nop at pc 0 when empty; link value wraps mod 2^32.
    always_comb begin
        head      = mem[rd_ptr];
        out_pc    = out_valid ? head.pc    : 32'h0;
        out_instr = out_valid ? head.instr : 32'h0;
        out_pc8   = out_pc + 32'd8;
        count     = cnt_q;
    end

endmodule

// File: tb/tb_fetch_buffer.sv
// tb_fetch_buffer: directed checks of the prefetch FIFO with hand-computed values.
module tb_fetch_buffer;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc;
    logic [31:0] in_instr;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_pc8;
    logic [31:0] out_instr;
    logic        flush;
    logic [2:0]  count;

    int n_tests = 0;
    int n_fail  = 0;

    fetch_buffer #(.DEPTH(4), .AW(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pc     (in_pc),
        .in_instr  (in_instr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pc    (out_pc),
        .out_pc8   (out_pc8),
        .out_instr (out_instr),
        .flush     (flush),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0; in_valid = 1'b0; in_pc = '0; in_instr = '0;
        out_ready = 1'b0; flush = 1'b0;

        // 1. reset held for 3 cycles, then released with no traffic
        repeat (3) tick();
        chk("rst_cnt_low", 32'(count), 32'd0);
        reset = 1'b1;
        tick();
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_ready", 32'(in_ready), 32'd1);
        chk("rst_cnt", 32'(count), 32'd0);
        chk("rst_instr", out_instr, 32'h0);
        chk("rst_pc", out_pc, 32'h0);
        chk("rst_pc8", out_pc8, 32'd8);

        // 2. fill with out_ready low
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_pc    = 32'h3000 + 32'(4 * i);
            in_instr = 32'hA000_0000 + 32'(i);
            tick();
        end
        chk("full_cnt", 32'(count), 32'd4);
        chk("full_ready", 32'(in_ready), 32'd0);
        chk("full_head", out_pc, 32'h3000);
        chk("full_instr", out_instr, 32'hA000_0000);
        in_pc = 32'h3010; in_instr = 32'hA000_0004;
        tick();
        chk("full_nopush_cnt", 32'(count), 32'd4);
        chk("full_nopush_head", out_pc, 32'h3000);

        // 3. single pop from full; the push offered that cycle is refused
        out_ready = 1'b1;
        tick();
        chk("pop1_head", out_pc, 32'h3004);
        chk("pop1_cnt", 32'(count), 32'd3);
        chk("pop1_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b0;
        tick();
        chk("wrap_push_cnt", 32'(count), 32'd4);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("drain_valid", 32'(out_valid), 32'd1);
            chk("drain_pc", out_pc, 32'h3004 + 32'(4 * i));
            chk("drain_instr", out_instr, 32'hA000_0001 + 32'(i));
            tick();
        end
        chk("drain_empty_cnt", 32'(count), 32'd0);
        chk("drain_empty_valid", 32'(out_valid), 32'd0);
        tick();
        chk("empty_ignore_ready", 32'(count), 32'd0);
        chk("empty_instr", out_instr, 32'h0);

        // 4. steady-state push+pop at count=2
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_pc = 32'h5000; in_instr = 32'hB000_0000; tick();
        in_pc = 32'h5004; in_instr = 32'hB000_0001; tick();
        chk("ss_start_cnt", 32'(count), 32'd2);
        out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            in_pc    = 32'h5008 + 32'(4 * k);
            in_instr = 32'hB000_0002 + 32'(k);
            chk("ss_pc", out_pc, 32'h5000 + 32'(4 * k));
            chk("ss_pc8", out_pc8, 32'h5008 + 32'(4 * k));
            tick();
            chk("ss_cnt", 32'(count), 32'd2);
        end
        chk("ss_end_head", out_pc, 32'h5018);

        // 5. flush at count=3 beats a simultaneous push and pop
        out_ready = 1'b0;
        in_pc = 32'h5020; in_instr = 32'hB000_0008;
        tick();
        chk("pre_flush_cnt", 32'(count), 32'd3);
        flush = 1'b1; out_ready = 1'b1; in_pc = 32'h6000;
        tick();
        flush = 1'b0; out_ready = 1'b0; in_valid = 1'b0;
        chk("flush_cnt", 32'(count), 32'd0);
        chk("flush_valid", 32'(out_valid), 32'd0);
        chk("flush_pc", out_pc, 32'h0);
        in_valid = 1'b1; in_pc = 32'h4000; in_instr = 32'hC000_0000;
        tick();
        in_valid = 1'b0;
        chk("post_flush_pc", out_pc, 32'h4000);
        chk("post_flush_valid", 32'(out_valid), 32'd1);
        chk("post_flush_cnt", 32'(count), 32'd1);

        // 6. asynchronous reset mid-cycle with count=2
        in_valid = 1'b1; in_pc = 32'h4004; in_instr = 32'hC000_0001;
        tick();
        in_valid = 1'b0;
        chk("pre_arst_cnt", 32'(count), 32'd2);
        @(negedge clk);
        #1 reset = 1'b0;
        #1;
        chk("arst_valid", 32'(out_valid), 32'd0);
        chk("arst_cnt", 32'(count), 32'd0);
        chk("arst_pc8", out_pc8, 32'd8);
        #1 reset = 1'b1;
        tick();
        in_valid = 1'b1; in_pc = 32'hFFFF_FFFC; in_instr = 32'hD000_0000;
        tick();
        in_valid = 1'b0;
        chk("wrap_pc", out_pc, 32'hFFFF_FFFC);
        chk("wrap_pc8", out_pc8, 32'h0000_0004);
        chk("wrap_cnt", 32'(count), 32'd1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("final_empty", 32'(out_valid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
